// File: rtl/aer_synapse_array.sv
// AER-driven synapse array: accumulates weighted pre-synaptic events per output neuron,
// publishes currents at end-of-timestep and optionally runs a row-serial pair-based STDP sweep.
module aer_synapse_array #(
    parameter int unsigned N_IN = 5,
    parameter int unsigned N_OUT = 2,
    parameter int unsigned W_WIDTH = 18,
    parameter int unsigned ACC_WIDTH = 20,
    parameter logic signed [W_WIDTH-1:0] INIT_WEIGHT = 18'sh0_10000,
    parameter int unsigned LTP_STEP = 256,
    parameter int unsigned LTD_STEP = 128,
    parameter int W_MAX = 2 ** (W_WIDTH - 1) - 1,
    parameter int W_MIN = 0,
    localparam int unsigned AW = $clog2(N_IN),
    localparam int unsigned OW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         aer_valid_i,
    output logic                         aer_ready_o,
    input  logic [AW-1:0]                aer_addr_i,
    input  logic                         aer_eot_i,
    input  logic                         learn_en_i,
    input  logic [N_OUT-1:0]             post_i,
    output logic [N_OUT*ACC_WIDTH-1:0]   out_o,
    output logic                         out_valid_o,
    output logic                         busy_o,
    input  logic [AW-1:0]                wt_rd_in_i,
    input  logic [OW-1:0]                wt_rd_out_i,
    output logic [W_WIDTH-1:0]           wt_rd_data_o
);

    typedef enum logic [0:0] {StAccum, StLearn} state_e;

    localparam logic [AW:0]             NInX    = N_IN[AW:0];
    localparam logic [OW:0]             NOutX   = N_OUT[OW:0];
    localparam logic [AW-1:0]           LastRow = AW'(N_IN - 1);
    localparam logic signed [W_WIDTH:0] LtpX    = LTP_STEP[W_WIDTH:0];
    localparam logic signed [W_WIDTH:0] LtdX    = LTD_STEP[W_WIDTH:0];
    localparam logic signed [W_WIDTH:0] WMaxX   = W_MAX[W_WIDTH:0];
    localparam logic signed [W_WIDTH:0] WMinX   = W_MIN[W_WIDTH:0];

    state_e                       state_q, state_d;
    logic [AW-1:0]                row_q, row_d;
    logic [N_IN-1:0]              pre_q, pre_d;
    logic [N_OUT-1:0]             post_q, post_d;
    logic [N_OUT*ACC_WIDTH-1:0]   out_q, out_d;
    logic                         out_valid_q, out_valid_d;
    logic [W_WIDTH-1:0]           rd_q, rd_d;
    logic signed [W_WIDTH-1:0]    w_q [N_IN][N_OUT];
    logic signed [W_WIDTH-1:0]    w_d [N_IN][N_OUT];
    logic signed [ACC_WIDTH-1:0]  acc_q [N_OUT];
    logic signed [ACC_WIDTH-1:0]  acc_d [N_OUT];

    logic accept;
    logic addr_ok;

    // Add one sign-extended weight, clamping to the signed accumulator range.
    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [W_WIDTH-1:0]   w
    );
        logic signed [ACC_WIDTH:0] ae;
        logic signed [ACC_WIDTH:0] we;
        logic signed [ACC_WIDTH:0] s;
        ae = a;
        we = w;
        s  = ae + we;
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        return s[ACC_WIDTH-1:0];
    endfunction

    function automatic logic signed [W_WIDTH-1:0] stdp(
        input logic signed [W_WIDTH-1:0] w,
        input logic                      potentiate
    );
        logic signed [W_WIDTH:0] x;
        logic signed [W_WIDTH:0] s;
        x = w;
        s = potentiate ? (x + LtpX) : (x - LtdX);
        if (s > WMaxX) begin
            s = WMaxX;
        end else if (s < WMinX) begin
            s = WMinX;
        end
        return s[W_WIDTH-1:0];
    endfunction

    assign aer_ready_o  = (state_q == StAccum);
    assign busy_o       = (state_q == StLearn);
    assign out_o        = out_q;
    assign out_valid_o  = out_valid_q;
    assign wt_rd_data_o = rd_q;

    assign accept  = aer_valid_i & (state_q == StAccum);
    assign addr_ok = ({1'b0, aer_addr_i} < NInX);

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        pre_d       = pre_q;
        post_d      = post_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        w_d         = w_q;
        acc_d       = acc_q;

        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    if (aer_eot_i) begin
                        for (int j = 0; j < N_OUT; j++) begin
                            out_d[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[j];
                            acc_d[j] = '0;
                        end
                        out_valid_d = 1'b1;
                        post_d      = post_i;
                        if (learn_en_i) begin
                            state_d = StLearn;
                            row_d   = '0;
                        end else begin
                            pre_d = '0;
                        end
                    end else if (addr_ok) begin
                        for (int j = 0; j < N_OUT; j++) begin
                            acc_d[j] = sat_acc(acc_q[j], w_q[aer_addr_i][j]);
                        end
                        pre_d[aer_addr_i] = 1'b1;
                    end
                end
            end
            StLearn: begin
                // One row per cycle; rows whose input stayed silent are left untouched.
                if (pre_q[row_q]) begin
                    for (int j = 0; j < N_OUT; j++) begin
                        w_d[row_q][j] = stdp(w_q[row_q][j], post_q[j]);
                    end
                end
                if (row_q == LastRow) begin
                    state_d = StAccum;
                    row_d   = '0;
                    pre_d   = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_comb begin
        rd_d = '0;
        if (({1'b0, wt_rd_in_i} < NInX) && ({1'b0, wt_rd_out_i} < NOutX)) begin
            rd_d = w_q[wt_rd_in_i][wt_rd_out_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StAccum;
            row_q       <= '0;
            pre_q       <= '0;
            post_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            for (int i = 0; i < N_IN; i++) begin
                for (int j = 0; j < N_OUT; j++) begin
                    w_q[i][j] <= INIT_WEIGHT;
                end
            end
            for (int j = 0; j < N_OUT; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            pre_q       <= pre_d;
            post_q      <= post_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            rd_q        <= rd_d;
            w_q         <= w_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_aer_synapse_array.sv
// Self-checking bench for aer_synapse_array: directed vector table, hand-written corner
// sequences and randomized steps checked against a step-level behavioural model.
module tb_aer_synapse_array;

    localparam int N_IN   = 5;
    localparam int N_OUT  = 2;
    localparam int WW     = 18;
    localparam int AWD    = 20;
    localparam int AW     = 3;
    localparam int OW     = 1;
    localparam int WINIT  = 65536;
    localparam int WMAX   = 131071;
    localparam int WMIN   = 0;
    localparam int LTP    = 256;
    localparam int LTD    = 128;
    localparam int ACCMAX = 524287;
    localparam int ACCMIN = -524288;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     aer_valid;
    logic                     aer_ready;
    logic [AW-1:0]            aer_addr;
    logic                     aer_eot;
    logic                     learn_en;
    logic [N_OUT-1:0]         post;
    logic [N_OUT*AWD-1:0]     out;
    logic                     out_valid;
    logic                     busy;
    logic [AW-1:0]            wt_rd_in;
    logic [OW-1:0]            wt_rd_out;
    logic [WW-1:0]            wt_rd_data;

    aer_synapse_array dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .aer_valid_i  (aer_valid),
        .aer_ready_o  (aer_ready),
        .aer_addr_i   (aer_addr),
        .aer_eot_i    (aer_eot),
        .learn_en_i   (learn_en),
        .post_i       (post),
        .out_o        (out),
        .out_valid_o  (out_valid),
        .busy_o       (busy),
        .wt_rd_in_i   (wt_rd_in),
        .wt_rd_out_i  (wt_rd_out),
        .wt_rd_data_o (wt_rd_data)
    );

    always #5 clk = ~clk;

    int ntest = 0;
    int nfail = 0;

    // Behavioural model: weight matrix, fired-input set, per-output running sums.
    int mw [N_IN][N_OUT];
    bit mpre [N_IN];
    int macc [N_OUT];
    int mout [N_OUT];

    typedef struct packed {
        int          n_ev;
        logic [23:0] addrs;
        int          exp0;
        int          exp1;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        ntest++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int dut_out(input int j);
        logic signed [AWD-1:0] v;
        v = out[j*AWD +: AWD];
        return int'(v);
    endfunction

    task automatic model_reset;
        for (int i = 0; i < N_IN; i++) begin
            mpre[i] = 1'b0;
            for (int j = 0; j < N_OUT; j++) mw[i][j] = WINIT;
        end
        for (int j = 0; j < N_OUT; j++) begin
            macc[j] = 0;
            mout[j] = 0;
        end
    endtask

    task automatic do_reset(input int cycles);
        reset     = 1'b1;
        aer_valid = 1'b0;
        aer_eot   = 1'b0;
        repeat (cycles) tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send_event(input int addr);
        aer_valid = 1'b1;
        aer_eot   = 1'b0;
        aer_addr  = addr[AW-1:0];
        tick();
        aer_valid = 1'b0;
        aer_addr  = AW'($urandom);
        if (addr < N_IN) begin
            mpre[addr] = 1'b1;
            for (int j = 0; j < N_OUT; j++) begin
                macc[j] = macc[j] + mw[addr][j];
                if (macc[j] > ACCMAX) macc[j] = ACCMAX;
                if (macc[j] < ACCMIN) macc[j] = ACCMIN;
            end
        end
    endtask

    task automatic send_eot(input bit learn, input logic [N_OUT-1:0] p);
        int n;
        aer_valid = 1'b1;
        aer_eot   = 1'b1;
        learn_en  = learn;
        post      = p;
        aer_addr  = AW'($urandom);
        tick();
        aer_valid = 1'b0;
        aer_eot   = 1'b0;
        learn_en  = 1'($urandom);
        post      = 2'($urandom);
        for (int j = 0; j < N_OUT; j++) begin
            mout[j] = macc[j];
            macc[j] = 0;
        end
        check("out_valid_after_eot", int'(out_valid), 1);
        for (int j = 0; j < N_OUT; j++) check($sformatf("out[%0d]", j), dut_out(j), mout[j]);
        if (learn) begin
            n = 0;
            while (busy === 1'b1 && n < 3 * N_IN) begin
                check("ready_low_in_learn", int'(aer_ready), 0);
                n++;
                tick();
                if (n == 1) check("out_valid_one_cycle", int'(out_valid), 0);
            end
            check("learn_cycles", n, N_IN);
            check("ready_after_learn", int'(aer_ready), 1);
            for (int i = 0; i < N_IN; i++) begin
                if (mpre[i]) begin
                    for (int j = 0; j < N_OUT; j++) begin
                        mw[i][j] = mw[i][j] + (p[j] ? LTP : -LTD);
                        if (mw[i][j] > WMAX) mw[i][j] = WMAX;
                        if (mw[i][j] < WMIN) mw[i][j] = WMIN;
                    end
                end
            end
        end else begin
            tick();
            check("out_valid_one_cycle", int'(out_valid), 0);
            check("busy_no_learn", int'(busy), 0);
        end
        for (int j = 0; j < N_OUT; j++) check($sformatf("out_hold[%0d]", j), dut_out(j), mout[j]);
        for (int i = 0; i < N_IN; i++) mpre[i] = 1'b0;
    endtask

    task automatic rd_weight(input int i, input int j, output int v);
        wt_rd_in  = i[AW-1:0];
        wt_rd_out = j[OW-1:0];
        tick();
        v = int'(wt_rd_data);
    endtask

    task automatic check_weights;
        int v;
        for (int i = 0; i < N_IN; i++) begin
            for (int j = 0; j < N_OUT; j++) begin
                rd_weight(i, j, v);
                check($sformatf("w[%0d][%0d]", i, j), v, mw[i][j]);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", ntest);
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        vecs[0] = '{n_ev: 3, addrs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd1, 3'd0},
                    exp0: 196608, exp1: 196608};
        vecs[1] = '{n_ev: 0, addrs: 24'd0, exp0: 0, exp1: 0};
        vecs[2] = '{n_ev: 8, addrs: {8{3'd3}}, exp0: 524287, exp1: 524287};
        vecs[3] = '{n_ev: 5, addrs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd6, 3'd5},
                    exp0: 131072, exp1: 131072};
        vecs[4] = '{n_ev: 1, addrs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2},
                    exp0: 65536, exp1: 65536};

        reset     = 1'b1;
        aer_valid = 1'b0;
        aer_eot   = 1'b0;
        aer_addr  = '0;
        learn_en  = 1'b0;
        post      = '0;
        wt_rd_in  = '0;
        wt_rd_out = '0;
        repeat (3) tick();
        check("reset_out0", dut_out(0), 0);
        check("reset_out1", dut_out(1), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(aer_ready), 1);
        check("reset_wt_rd_data", int'(wt_rd_data), 0);
        reset = 1'b0;
        model_reset();

        // Directed table, learning off so every weight stays at its initial value.
        for (int k = 0; k < 5; k++) begin
            for (int e = 0; e < vecs[k].n_ev; e++) send_event(int'(vecs[k].addrs[e*3 +: 3]));
            send_eot(1'b0, 2'b00);
            check($sformatf("vec%0d_out0", k), dut_out(0), vecs[k].exp0);
            check($sformatf("vec%0d_out1", k), dut_out(1), vecs[k].exp1);
        end
        check_weights();

        // STDP on rows 1 and 4 with only post neuron 0 firing.
        send_event(1);
        send_event(4);
        send_eot(1'b1, 2'b01);
        rd_weight(1, 0, v); check("stdp_w10", v, 65792);
        rd_weight(4, 0, v); check("stdp_w40", v, 65792);
        rd_weight(1, 1, v); check("stdp_w11", v, 65408);
        rd_weight(4, 1, v); check("stdp_w41", v, 65408);
        rd_weight(0, 0, v); check("stdp_w00", v, 65536);
        rd_weight(3, 1, v); check("stdp_w31", v, 65536);
        check_weights();

        // Out-of-range and duplicate addresses with learning: only row 0 moves, once.
        send_event(5);
        send_event(6);
        send_event(7);
        send_event(0);
        send_event(0);
        send_eot(1'b1, 2'b10);
        rd_weight(0, 0, v); check("dup_w00", v, 65408);
        rd_weight(0, 1, v); check("dup_w01", v, 65792);
        check_weights();

        // Randomized steps against the model.
        for (int s = 0; s < 40; s++) begin
            int nev;
            nev = $urandom_range(0, 6);
            for (int e = 0; e < nev; e++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_event($urandom_range(0, 7));
            end
            send_eot(1'($urandom), 2'($urandom));
            if (s % 8 == 7) check_weights();
        end
        check_weights();

        // Upper and lower weight clamps.
        do_reset(2);
        for (int k = 0; k < 300; k++) begin
            send_event(0);
            send_eot(1'b1, 2'b11);
        end
        rd_weight(0, 0, v); check("clamp_hi_w00", v, WMAX);
        rd_weight(0, 1, v); check("clamp_hi_w01", v, WMAX);
        for (int k = 0; k < 1100; k++) begin
            send_event(0);
            send_eot(1'b1, 2'b00);
        end
        rd_weight(0, 0, v); check("clamp_lo_w00", v, 0);
        rd_weight(0, 1, v); check("clamp_lo_w01", v, 0);
        check_weights();

        // Reset asserted during the third LEARN cycle.
        do_reset(1);
        send_event(2);
        send_event(0);
        aer_valid = 1'b1;
        aer_eot   = 1'b1;
        learn_en  = 1'b1;
        post      = 2'b11;
        tick();
        aer_valid = 1'b0;
        aer_eot   = 1'b0;
        check("midlearn_busy_c1", int'(busy), 1);
        tick();
        tick();
        check("midlearn_busy_c3", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check("midlearn_busy_after_reset", int'(busy), 0);
        check("midlearn_ready_after_reset", int'(aer_ready), 1);
        check("midlearn_out_valid", int'(out_valid), 0);
        check("midlearn_out0", dut_out(0), 0);
        check_weights();
        // Flags and accumulators must be clear: an empty learning step changes nothing.
        send_eot(1'b1, 2'b11);
        check_weights();

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
